// File: rtl/cnn_stream_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_stream_pkg                                                           |
// | Constants and helpers shared by the pixel feeder and the 3x3 window      |
// | line-buffer controller: feeder state encoding, row/line-buffer count     |
// | derivation and the image address width.                                  |
// | Ports: none (package).                                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package cnn_stream_pkg;

  // Feeder control states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LINE  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } feeder_state_e;

  // Number of output rows a KY-tall window produces over an F-row image.
  function automatic int rows_expected(input int f, input int ky);
    return f - ky + 1;
  endfunction

  // Line buffers the window controller keeps: one more than the kernel
  // height so a new line can be written while KY lines are being read.
  function automatic int line_buffers(input int ky);
    return ky + 1;
  endfunction

  // Address width for an F x F image stored row-major.
  function automatic int addr_width(input int f);
    return (f > 1) ? $clog2(f * f) : 1;
  endfunction

endpackage : cnn_stream_pkg
`default_nettype wire

// File: rtl/pixel_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_feeder_if                                                          |
// | Bus bundle between the pixel feeder, its image memory and the window     |
// | controller.                                                              |
// | Signals: o_mem_rd_en / o_mem_addr  - read request to image memory        |
// |          i_mem_data                - read data, one cycle after request  |
// |          o_pixel_data / _valid     - raster pixel stream                 |
// | Modports: master (feeder side), slave (memory + window controller side)  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface pixel_feeder_if #(
  parameter int F = 28,
  parameter int B = 8
);
  import cnn_stream_pkg::*;

  localparam int AW = addr_width(F);

  logic          o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [B-1:0]  i_mem_data;
  logic [B-1:0]  o_pixel_data;
  logic          o_pixel_data_valid;

  modport master (
    output o_mem_rd_en,
    output o_mem_addr,
    input  i_mem_data,
    output o_pixel_data,
    output o_pixel_data_valid
  );

  modport slave (
    input  o_mem_rd_en,
    input  o_mem_addr,
    output i_mem_data,
    input  o_pixel_data,
    input  o_pixel_data_valid
  );

endinterface : pixel_feeder_if
`default_nettype wire

// File: rtl/pixel_feeder_rd_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_feeder_rd_pipe                                                     |
// | Two-stage valid delay that lines the synchronous memory read data up     |
// | with its qualifier. Data is captured once, when the memory presents it.  |
// | Ports: i_clk, i_rst     - clock, synchronous active-high reset           |
// |        rd_en_i          - memory read enable issued this cycle           |
// |        mem_data_i       - memory data (valid one cycle after rd_en_i)    |
// |        pixel_data_o     - registered pixel                               |
// |        pixel_valid_o    - pixel qualifier, rd_en_i delayed by two        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pixel_feeder_rd_pipe #(
  parameter int B = 8
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  input  wire logic         rd_en_i,
  input  wire logic [B-1:0] mem_data_i,
  output logic      [B-1:0] pixel_data_o,
  output logic              pixel_valid_o
);

  logic         rd_vld_q;   // memory data on mem_data_i is meaningful
  logic         out_vld_q;
  logic [B-1:0] data_q;

  // Reset clears both valid stages, so any read already in flight is
  // dropped and never shows up as a pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      data_q    <= '0;
    end else begin
      rd_vld_q  <= rd_en_i;
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        data_q <= mem_data_i;
      end
    end
  end

  assign pixel_data_o  = data_q;
  assign pixel_valid_o = out_vld_q;

endmodule : pixel_feeder_rd_pipe
`default_nettype wire

// File: rtl/pixel_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_feeder                                                             |
// | Streams an F x F image out of a synchronous-read memory in raster order. |
// | Sends INIT_LINES lines up front, then one line per row-complete credit   |
// | from the window controller, and pulses o_done once all output rows of    |
// | the frame have been acknowledged.                                        |
// | Ports: i_clk, i_rst - clock, synchronous active-high reset               |
// |        i_start      - start pulse, honoured only when idle               |
// |        i_intr       - row-complete interrupt, one credit per high cycle  |
// |        o_busy       - high whenever a frame is in progress               |
// |        o_done       - one-cycle frame completion pulse                   |
// |        px_bus       - memory read port and pixel stream (master side)    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module pixel_feeder
  import cnn_stream_pkg::*;
#(
  parameter int F          = 28,
  parameter int B          = 8,
  parameter int KY         = 3,
  parameter int INIT_LINES = 4
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst,
  input  wire logic      i_start,
  input  wire logic      i_intr,
  output logic           o_busy,
  output logic           o_done,
  pixel_feeder_if.master px_bus
);

  localparam int ROWS = rows_expected(F, KY);
  localparam int AW   = addr_width(F);
  localparam int CW   = $clog2(F);
  localparam int NW   = $clog2(F + 1);

  localparam logic [CW-1:0] c_col_last   = CW'(F - 1);
  localparam logic [AW-1:0] c_addr_last  = AW'(F * F - 1);
  localparam logic [NW-1:0] c_lines_all  = NW'(F);
  localparam logic [NW-1:0] c_init_last  = NW'(INIT_LINES - 1);
  localparam logic [NW-1:0] c_credit_max = NW'(F);
  localparam logic [NW-1:0] c_rows       = NW'(ROWS);

  generate
    if (F < 4) begin : g_bad_f
      $error("pixel_feeder: F must be at least 4");
    end
    if (INIT_LINES < 1 || INIT_LINES > F) begin : g_bad_init
      $error("pixel_feeder: INIT_LINES must be within 1..F");
    end
    if (KY < 1 || KY > F) begin : g_bad_ky
      $error("pixel_feeder: KY must be within 1..F");
    end
  endgenerate

  feeder_state_e state_q, state_d;

  logic [CW-1:0] col_q,        col_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [NW-1:0] lines_sent_q, lines_sent_d;
  logic [NW-1:0] credit_q,     credit_d;
  logic [NW-1:0] intr_total_q, intr_total_d;

  logic rd_en;        // issue a memory read this cycle
  logic consume;      // WAIT takes one credit to start a line
  logic line_end;     // current read is the last column of its line
  logic start_frame;  // accepted start: counters restart from zero
  logic intr_acc;     // interrupt that counts toward credit and total

  assign line_end    = (col_q == c_col_last);
  assign start_frame = (state_q == ST_IDLE) && i_start;
  // Idle interrupts belong to no frame; once every row has been
  // acknowledged further interrupts carry no meaning either.
  assign intr_acc    = i_intr && (state_q != ST_IDLE) && (intr_total_q != c_rows);

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    consume = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        rd_en = 1'b1;
        if (line_end && (lines_sent_q == c_init_last)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Every line sent: nothing left to read, only acknowledgements.
        if (lines_sent_q == c_lines_all) begin
          state_d = ST_DRAIN;
        end else if (credit_q != '0) begin
          state_d = ST_LINE;
          consume = 1'b1;
        end
      end
      ST_LINE: begin
        rd_en = 1'b1;
        if (line_end) begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (intr_total_q == c_rows) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Position, line and credit counters
  // ---------------------------------------------------------------------
  always_comb begin
    col_d        = col_q;
    addr_d       = addr_q;
    lines_sent_d = lines_sent_q;
    credit_d     = credit_q;
    intr_total_d = intr_total_q;
    if (start_frame) begin
      col_d        = '0;
      addr_d       = '0;
      lines_sent_d = '0;
      credit_d     = '0;
      intr_total_d = '0;
    end else begin
      if (rd_en) begin
        col_d = line_end ? '0 : col_q + 1'b1;
        // Hold on the last pixel rather than wrapping past the image.
        if (addr_q != c_addr_last) begin
          addr_d = addr_q + 1'b1;
        end
        if (line_end) begin
          lines_sent_d = lines_sent_q + 1'b1;
        end
      end
      // A credit arriving in the same cycle one is spent leaves the count
      // unchanged, even at saturation.
      case ({intr_acc, consume})
        2'b10: begin
          if (credit_q != c_credit_max) begin
            credit_d = credit_q + 1'b1;
          end
        end
        2'b01: begin
          credit_d = credit_q - 1'b1;
        end
        default: begin
          credit_d = credit_q;
        end
      endcase
      if (intr_acc) begin
        intr_total_d = intr_total_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q        <= '0;
      addr_q       <= '0;
      lines_sent_q <= '0;
      credit_q     <= '0;
      intr_total_q <= '0;
    end else begin
      col_q        <= col_d;
      addr_q       <= addr_d;
      lines_sent_q <= lines_sent_d;
      credit_q     <= credit_d;
      intr_total_q <= intr_total_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign px_bus.o_mem_rd_en = rd_en;
  assign px_bus.o_mem_addr  = addr_q;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_done             = (state_q == ST_DONE);

  pixel_feeder_rd_pipe #(
    .B (B)
  ) u_rd_pipe (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .rd_en_i       (rd_en),
    .mem_data_i    (px_bus.i_mem_data),
    .pixel_data_o  (px_bus.o_pixel_data),
    .pixel_valid_o (px_bus.o_pixel_data_valid)
  );

endmodule : pixel_feeder
`default_nettype wire

// File: tb/tb_pixel_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_feeder                                                          |
// | Self-checking bench for pixel_feeder at F=6. Frame schedules are         |
// | predicted from the transfer rules (initial burst, one line per credit,   |
// | completion after the last acknowledgement) and compared cycle by cycle.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pixel_feeder;

  localparam int F    = 6;
  localparam int B    = 8;
  localparam int KY   = 3;
  localparam int IL   = 4;
  localparam int ROWS = F - KY + 1;
  localparam int LEN  = 140;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic intr  = 1'b0;
  logic busy;
  logic done;

  pixel_feeder_if #(.F(F), .B(B)) bus ();

  pixel_feeder #(
    .F(F), .B(B), .KY(KY), .INIT_LINES(IL)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_intr  (intr),
    .o_busy  (busy),
    .o_done  (done),
    .px_bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read image memory
  logic [B-1:0] mem [F*F];
  logic [B-1:0] rdata = '0;
  always @(posedge clk) if (bus.o_mem_rd_en) rdata <= mem[bus.o_mem_addr];
  assign bus.i_mem_data = rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus and expected schedule -----------------------
  bit intr_vec  [LEN+1];
  bit start_vec [LEN+1];
  bit m_rd   [LEN+3];
  int m_addr [LEN+3];
  bit m_vld  [LEN+3];
  int m_pix  [LEN+3];
  bit m_busy [LEN+3];
  bit m_done [LEN+3];

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Offsets are relative to the cycle carrying i_start (offset 0).
  task automatic build_model();
    int p[$];
    int e, s, n, d;
    for (int o = 0; o < LEN + 3; o++) begin
      m_rd[o] = 0; m_addr[o] = 0; m_vld[o] = 0; m_pix[o] = 0; m_busy[o] = 0; m_done[o] = 0;
    end
    for (int o = 1; o <= LEN; o++) if (intr_vec[o]) p.push_back(o);
    if (p.size() < ROWS) begin
      errors++;
      $display("FAIL model_setup: got %0d interrupts, expected at least %0d", p.size(), ROWS);
      return;
    end
    n = 0;
    // Burst: reads back to back from offset 1.
    for (int o = 1; o <= IL * F; o++) begin
      m_rd[o] = 1; m_addr[o] = n; m_vld[o+2] = 1; m_pix[o+2] = int'(mem[n]); n++;
    end
    e = IL * F;
    // Each further line needs the next credit (usable two cycles after its
    // interrupt) and one spare cycle after the previous line.
    for (int k = 0; k < F - IL; k++) begin
      s = max2(e + 2, p[k] + 2);
      for (int o = s; o < s + F; o++) begin
        m_rd[o] = 1; m_addr[o] = n; m_vld[o+2] = 1; m_pix[o+2] = int'(mem[n]); n++;
      end
      e = s + F - 1;
    end
    d = max2(e + 3, p[ROWS-1] + 2);
    for (int o = 1; o <= d; o++) m_busy[o] = 1;
    m_done[d] = 1;
  endtask

  int obs_start [F];
  int obs_done, done_cnt, vld_cnt;

  task automatic run_frame(input int idle_pulses);
    for (int i = 0; i < idle_pulses; i++) begin
      @(posedge clk); #1 start = 1'b0; intr = 1'b1;
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_rd_en", int'(bus.o_mem_rd_en), 0);
    end
    build_model();
    for (int l = 0; l < F; l++) obs_start[l] = -1;
    obs_done = -1; done_cnt = 0; vld_cnt = 0;
    for (int off = 0; off <= LEN; off++) begin
      @(posedge clk); #1 start = (off == 0) || start_vec[off]; intr = intr_vec[off];
      @(negedge clk);
      check($sformatf("rd_en@%0d", off), int'(bus.o_mem_rd_en), int'(m_rd[off]));
      if (m_rd[off]) check($sformatf("addr@%0d", off), int'(bus.o_mem_addr), m_addr[off]);
      check($sformatf("valid@%0d", off), int'(bus.o_pixel_data_valid), int'(m_vld[off]));
      if (m_vld[off]) check($sformatf("pixel@%0d", off), int'(bus.o_pixel_data), m_pix[off]);
      check($sformatf("busy@%0d", off), int'(busy), int'(m_busy[off]));
      check($sformatf("done@%0d", off), int'(done), int'(m_done[off]));
      if (bus.o_mem_rd_en && (int'(bus.o_mem_addr) % F == 0))
        obs_start[int'(bus.o_mem_addr) / F] = off;
      if (done) begin done_cnt++; obs_done = off; end
      if (bus.o_pixel_data_valid) vld_cnt++;
    end
    @(posedge clk); #1 start = 1'b0; intr = 1'b0;
  endtask

  // ---------------- directed scenario table ------------------------------
  typedef struct packed {
    logic [7:0]      idle_pulses;
    logic [3:0]      n_intr;
    logic [5:0][7:0] intr_off;
    logic [7:0]      start_off;   // extra i_start inside the frame, 0 = none
    logic [7:0]      exp_l4;      // offset of first read of line 4
    logic [7:0]      exp_l5;      // offset of first read of line 5
    logic [7:0]      exp_done;
    logic [7:0]      exp_valid;
  } vec_t;
  vec_t tbl [5];

  task automatic set_row(input int idx, input int idle, input int n,
                         input int o0, input int o1, input int o2,
                         input int o3, input int o4, input int o5,
                         input int so, input int l4, input int l5, input int dn);
    vec_t r;
    r.idle_pulses = 8'(idle);
    r.n_intr      = 4'(n);
    r.intr_off[0] = 8'(o0); r.intr_off[1] = 8'(o1); r.intr_off[2] = 8'(o2);
    r.intr_off[3] = 8'(o3); r.intr_off[4] = 8'(o4); r.intr_off[5] = 8'(o5);
    r.start_off   = 8'(so);
    r.exp_l4      = 8'(l4);
    r.exp_l5      = 8'(l5);
    r.exp_done    = 8'(dn);
    r.exp_valid   = 8'(F * F);
    tbl[idx] = r;
  endtask

  task automatic load_row(input int t);
    for (int a = 0; a < F * F; a++) mem[a] = B'(a);
    for (int o = 0; o <= LEN; o++) begin intr_vec[o] = 0; start_vec[o] = 0; end
    for (int i = 0; i < int'(tbl[t].n_intr); i++) intr_vec[int'(tbl[t].intr_off[i])] = 1;
    if (tbl[t].start_off != 0) start_vec[int'(tbl[t].start_off)] = 1;
  endtask

  task automatic check_row(input int t);
    check($sformatf("row%0d_line4_start", t), obs_start[IL], int'(tbl[t].exp_l4));
    check($sformatf("row%0d_line5_start", t), obs_start[IL+1], int'(tbl[t].exp_l5));
    check($sformatf("row%0d_done_offset", t), obs_done, int'(tbl[t].exp_done));
    check($sformatf("row%0d_done_pulses", t), done_cnt, 1);
    check($sformatf("row%0d_valid_count", t), vld_cnt, int'(tbl[t].exp_valid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        idx idle n   interrupt offsets           xstart l4   l5   done
    set_row(0,  0,  4, 30,  40,  50,  60,  0,  0,   34,  32,  42,  62); // basic frame, start during LINE
    set_row(1,  0,  4,  5,  10,  60,  70,  0,  0,    0,  26,  33,  72); // two credits banked in INIT
    set_row(2,  0,  4,  5,  25,  50,  52,  0,  0,    0,  26,  33,  54); // credit in and out same cycle
    set_row(3, 10,  6, 30,  31,  32,  33, 34, 35,    0,  32,  39,  47); // idle + excess interrupts
    set_row(4,  2,  4,100, 102, 104, 106,  0,  0,  117, 102, 109, 117); // start during done cycle

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", int'(bus.o_mem_rd_en), 0);
    check("rst_addr", int'(bus.o_mem_addr), 0);
    check("rst_pixel", int'(bus.o_pixel_data), 0);
    check("rst_valid", int'(bus.o_pixel_data_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      load_row(t);
      run_frame(int'(tbl[t].idle_pulses));
      check_row(t);
    end

    // Reset while reading address 14 (row 2 of the burst)
    for (int a = 0; a < F * F; a++) mem[a] = B'(a);
    @(posedge clk); #1 start = 1'b1; intr = 1'b0;
    for (int off = 1; off <= 15; off++) begin
      @(posedge clk); #1 start = 1'b0; rst = (off == 15);
    end
    @(negedge clk);
    check("midrst_rd_en", int'(bus.o_mem_rd_en), 1);
    check("midrst_addr", int'(bus.o_mem_addr), 14);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_rd_en_after", int'(bus.o_mem_rd_en), 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("midrst_valid_%0d", i), int'(bus.o_pixel_data_valid), 0);
      @(negedge clk);
    end
    load_row(0);
    run_frame(0);
    check_row(0);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < F * F; a++) mem[a] = B'($urandom_range(0, 255));
      for (int o = 0; o <= LEN; o++) begin
        intr_vec[o]  = ($urandom_range(0, 7) == 0);
        start_vec[o] = 0;
      end
      intr_vec[100] = 1; intr_vec[102] = 1; intr_vec[104] = 1; intr_vec[106] = 1;
      start_vec[$urandom_range(1, 20)] = 1;
      run_frame(int'($urandom_range(0, 3)));
      check($sformatf("rand%0d_valid_count", r), vld_cnt, F * F);
      check($sformatf("rand%0d_done_pulses", r), done_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pixel_feeder
`default_nettype wire
